// File: rtl/module1_sched_pkg.sv
// Shared types and constants for the module1 round-robin scheduler.
package module1_sched_pkg;

  localparam int HIST_ENTRY_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] data;
  } hist_entry_t;

endpackage

// File: rtl/module1_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester found searching upward from ptr+1.
module module1_rr_arb #(
  parameter  int NUM_REQ = 3,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sel       = '0;
    // Offset 1 first so the previously granted requester has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/module1_sched.sv
// Round-robin scheduler sharing one module1 datapath among NUM_REQ requesters.
// Define MODULE1_SCHED_HIST_EN to keep a ring of completed responses.
module module1_sched
  import module1_sched_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  parameter  int P1      = 4,
  parameter  int P2      = 5,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int DEPTH   = 2 * P1,
  localparam int HC_W    = $clog2(DEPTH + 1),
  localparam int RD_W    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*P1-1:0]   req_in1,
  input  logic [NUM_REQ*P2-1:0]   req_in2,
  input  logic [NUM_REQ*4-1:0]    req_in3,
  output logic [P1-1:0]           dp_in1,
  output logic [P2-1:0]           dp_in2,
  output logic [3:0]              dp_in3,
  input  logic [P1-1:0]           dp_out1,
  input  logic [P1-1:0]           dp_out2,
  input  logic [P1-1:0]           dp_out3,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [P1-1:0]           rsp_out1,
  output logic [P1-1:0]           rsp_out2,
  output logic [P1-1:0]           rsp_out3,
  input  logic [RD_W-1:0]         hist_rd_idx,
  output logic [HIST_ENTRY_W-1:0] hist_rd_data,
  output logic [HC_W-1:0]         hist_count
);

  state_e            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  logic              rsp_fire;
  logic [P1-1:0]     sel_in1;
  logic [P2-1:0]     sel_in2;
  logic [3:0]        sel_in3;
  logic [P1-1:0]     in1_p0;
  logic [P2-1:0]     in2_p0;
  logic [3:0]        in3_p0;
  logic [ID_W-1:0]   id_p0;

  module1_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = (state == IDLE) && (|req_valid);
  assign rsp_valid = (state == RESP);
  assign rsp_fire  = rsp_valid && rsp_ready;

  // One-hot grant selects the winning operands without a variable part-select.
  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    sel_in3 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_in1 = sel_in1 | req_in1[i*P1 +: P1];
        sel_in2 = sel_in2 | req_in2[i*P2 +: P2];
        sel_in3 = sel_in3 | req_in3[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operands latched on grant, held from ISSUE through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= ID_W'(NUM_REQ - 1);
      in1_p0 <= '0;
      in2_p0 <= '0;
      in3_p0 <= '0;
      id_p0  <= '0;
    end else if (accept) begin
      ptr    <= grant_idx;
      in1_p0 <= sel_in1;
      in2_p0 <= sel_in2;
      in3_p0 <= sel_in3;
      id_p0  <= grant_idx;
    end
  end

  assign dp_in1 = (state == IDLE) ? '0 : in1_p0;
  assign dp_in2 = (state == IDLE) ? '0 : in2_p0;
  assign dp_in3 = (state == IDLE) ? '0 : in3_p0;

  // Stage p1: datapath results captured at the end of ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id   <= '0;
      rsp_out1 <= '0;
      rsp_out2 <= '0;
      rsp_out3 <= '0;
    end else if (state == ISSUE) begin
      rsp_id   <= id_p0;
      rsp_out1 <= dp_out1;
      rsp_out2 <= dp_out2;
      rsp_out3 <= dp_out3;
    end
  end

`ifdef MODULE1_SCHED_HIST_EN
  hist_entry_t     hist_mem [DEPTH];
  hist_entry_t     new_entry;
  logic [RD_W-1:0] wr_ptr;
  logic [HC_W-1:0] count;

  assign new_entry.id   = 4'(rsp_id);
  assign new_entry.data = 4'(rsp_out1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) hist_mem[i] <= '0;
    end else if (rsp_fire) begin
      hist_mem[wr_ptr] <= new_entry;
      wr_ptr <= (wr_ptr == RD_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (count != HC_W'(DEPTH)) count <= count + 1'b1;
    end
  end

  assign hist_rd_data = (int'(hist_rd_idx) < DEPTH) ? hist_mem[hist_rd_idx] : '0;
  assign hist_count   = count;
`else
  logic unused_hist;
  assign unused_hist  = (^hist_rd_idx) ^ rsp_fire;
  assign hist_rd_data = '0;
  assign hist_count   = '0;
`endif

endmodule

// File: tb/tb_module1_sched.sv
// Randomized self-checking bench for module1_sched against a transaction-level round-robin model.
module tb_module1_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_ready;
  logic [11:0] req_in1;
  logic [14:0] req_in2;
  logic [11:0] req_in3;
  logic [3:0]  dp_in1, dp_in3, dp_out1, dp_out2, dp_out3;
  logic [4:0]  dp_in2;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_out1, rsp_out2, rsp_out3;
  logic [2:0]  hist_rd_idx;
  logic [7:0]  hist_rd_data;
  logic [3:0]  hist_count;

  int checks = 0;
  int errors = 0;
  int m_last;
  logic [3:0] op1 [3];
  logic [4:0] op2 [3];
  logic [3:0] op3 [3];

  typedef struct {
    logic [2:0] grant;
    int         lat;
    logic [1:0] id;
    logic [3:0] o1, o2, o3;
    bit         stable;
    logic [2:0] busy_ready;
    logic       vld_after;
  } txn_obs_t;

  always #5 clk = ~clk;

  // Echo datapath: out1 = in1, out2 = in2 truncated to P1, out3 = in3.
  assign dp_out1 = dp_in1;
  assign dp_out2 = dp_in2[3:0];
  assign dp_out3 = dp_in3;

  module1_sched #(.NUM_REQ(3), .P1(4), .P2(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3),
    .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_in3(dp_in3),
    .dp_out1(dp_out1), .dp_out2(dp_out2), .dp_out3(dp_out3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out1(rsp_out1), .rsp_out2(rsp_out2), .rsp_out3(rsp_out3),
    .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data), .hist_count(hist_count)
  );

  // Next requester to win: first valid one after the last winner, wrapping.
  function automatic int rr_pick(input logic [2:0] mask, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < 3; i++) begin
      op1[i] = 4'($urandom);
      op2[i] = 5'($urandom);
      op3[i] = 4'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; hist_rd_idx = '0;
    req_in1 = '0; req_in2 = '0; req_in3 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 2;
    @(posedge clk); #1;
  endtask

  // Presents one request set at an IDLE point and follows it to the handshake; observes, never judges.
  task automatic drive_txn(input logic [2:0] mask, input int hold, output txn_obs_t ob);
    for (int i = 0; i < 3; i++) begin
      req_in1[i*4 +: 4] = op1[i];
      req_in2[i*5 +: 5] = op2[i];
      req_in3[i*4 +: 4] = op3[i];
    end
    req_valid = mask;
    rsp_ready = (hold == 0);
    #1;
    ob.grant = req_ready;
    ob.busy_ready = '0;
    ob.stable = 1'b1;
    ob.lat = 0;
    do begin
      @(posedge clk); #1;
      ob.lat++;
      ob.busy_ready |= req_ready;
    end while (!rsp_valid && ob.lat < 8);
    ob.id = rsp_id; ob.o1 = rsp_out1; ob.o2 = rsp_out2; ob.o3 = rsp_out3;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      ob.busy_ready |= req_ready;
      if (rsp_valid !== 1'b1 || rsp_id !== ob.id || rsp_out1 !== ob.o1 ||
          rsp_out2 !== ob.o2 || rsp_out3 !== ob.o3) ob.stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    ob.vld_after = rsp_valid;
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if ({rsp_id, rsp_out1, rsp_out2, rsp_out3} !== 14'h0) begin errors++; $display("FAIL reset_rsp_fields got %h want 0", {rsp_id, rsp_out1, rsp_out2, rsp_out3}); end
    checks++; if ({dp_in1, dp_in2, dp_in3} !== 13'h0) begin errors++; $display("FAIL reset_dp_in got %h want 0", {dp_in1, dp_in2, dp_in3}); end
    checks++; if (hist_count !== 4'd0) begin errors++; $display("FAIL reset_hist_count got %0d want 0", hist_count); end
    checks++; if (hist_rd_data !== 8'h00) begin errors++; $display("FAIL reset_hist_data got %h want 00", hist_rd_data); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (req_ready !== 3'b000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_no_req got ready=%b vld=%b want 000/0", req_ready, rsp_valid); end
    end
  endtask

  task automatic test_single();
    txn_obs_t ob;
    do_reset();
    randomize_ops();
    op1[1] = 4'hA; op2[1] = 5'h13; op3[1] = 4'h5;
    drive_txn(3'b010, 0, ob);
    m_last = 1;
    checks++; if (ob.grant !== 3'b010) begin errors++; $display("FAIL single_grant got %b want 010", ob.grant); end
    checks++; if (ob.lat !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", ob.lat); end
    checks++; if (ob.id !== 2'd1) begin errors++; $display("FAIL single_id got %0d want 1", ob.id); end
    checks++; if ({ob.o1, ob.o2, ob.o3} !== 12'hA35) begin errors++; $display("FAIL single_outs got %h want a35", {ob.o1, ob.o2, ob.o3}); end
    checks++; if (ob.vld_after !== 1'b0) begin errors++; $display("FAIL single_vld_drop got %b want 0", ob.vld_after); end
    checks++; if ({dp_in1, dp_in2, dp_in3} !== 13'h0) begin errors++; $display("FAIL single_dp_idle got %h want 0", {dp_in1, dp_in2, dp_in3}); end
  endtask

  task automatic test_fairness();
    txn_obs_t ob;
    time t0;
    int exp;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      randomize_ops();
      exp = rr_pick(3'b111, m_last);
      t0 = $time;
      drive_txn(3'b111, 0, ob);
      checks++; if (ob.grant !== 3'(1 << exp) || ob.id !== 2'(exp)) begin errors++; $display("FAIL fair_order[%0d] got grant=%b id=%0d want id %0d", n, ob.grant, ob.id, exp); end
      checks++; if (ob.o1 !== op1[exp] || ob.o2 !== op2[exp][3:0] || ob.o3 !== op3[exp]) begin errors++; $display("FAIL fair_data[%0d] got %h want %h", n, {ob.o1, ob.o2, ob.o3}, {op1[exp], op2[exp][3:0], op3[exp]}); end
      checks++; if (ob.lat !== 2) begin errors++; $display("FAIL fair_latency[%0d] got %0d want 2", n, ob.lat); end
      checks++; if ($time - t0 != 30) begin errors++; $display("FAIL fair_period[%0d] got %0t want 30", n, $time - t0); end
      m_last = exp;
    end
  endtask

  task automatic test_backpressure();
    txn_obs_t ob;
    int exp;
    for (int n = 0; n < 2; n++) begin
      randomize_ops();
      exp = rr_pick(3'b111, m_last);
      drive_txn(3'b111, 5, ob);
      checks++; if (ob.id !== 2'(exp)) begin errors++; $display("FAIL bp_id[%0d] got %0d want %0d", n, ob.id, exp); end
      checks++; if (ob.stable !== 1'b1) begin errors++; $display("FAIL bp_stable[%0d] got %b want 1", n, ob.stable); end
      checks++; if (ob.busy_ready !== 3'b000) begin errors++; $display("FAIL bp_no_accept[%0d] got %b want 000", n, ob.busy_ready); end
      checks++; if (ob.vld_after !== 1'b0) begin errors++; $display("FAIL bp_vld_drop[%0d] got %b want 0", n, ob.vld_after); end
      m_last = exp;
    end
  endtask

  task automatic test_random();
    txn_obs_t ob;
    logic [2:0] mask;
    int exp, hold;
    for (int n = 0; n < 24; n++) begin
      randomize_ops();
      mask = 3'($urandom_range(1, 7));
      hold = $urandom_range(0, 3);
      exp = rr_pick(mask, m_last);
      drive_txn(mask, hold, ob);
      checks++; if (ob.grant !== 3'(1 << exp)) begin errors++; $display("FAIL rnd_grant[%0d] got %b want %b (mask %b)", n, ob.grant, 3'(1 << exp), mask); end
      checks++; if (ob.id !== 2'(exp)) begin errors++; $display("FAIL rnd_id[%0d] got %0d want %0d", n, ob.id, exp); end
      checks++; if (ob.o1 !== op1[exp] || ob.o2 !== op2[exp][3:0] || ob.o3 !== op3[exp]) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", n, {ob.o1, ob.o2, ob.o3}, {op1[exp], op2[exp][3:0], op3[exp]}); end
      checks++; if (ob.lat !== 2 || ob.stable !== 1'b1 || ob.busy_ready !== 3'b000) begin errors++; $display("FAIL rnd_proto[%0d] got lat=%0d stable=%b busy=%b want 2/1/000", n, ob.lat, ob.stable, ob.busy_ready); end
      m_last = exp;
    end
  endtask

  task automatic test_reset_mid();
    txn_obs_t ob;
    randomize_ops();
    for (int i = 0; i < 3; i++) begin
      req_in1[i*4 +: 4] = op1[i] | 4'h1;
      req_in2[i*5 +: 5] = op2[i] | 5'h1;
      req_in3[i*4 +: 4] = op3[i] | 4'h1;
    end
    req_valid = 3'b100;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (dp_in1 === 4'h0) begin errors++; $display("FAIL mid_issue_dp got %h want nonzero", dp_in1); end
    rst = 1'b1;
    req_valid = '0;
    #1;
    checks++; if ({rsp_valid, req_ready, rsp_id, rsp_out1, rsp_out2, rsp_out3} !== 18'h0) begin errors++; $display("FAIL mid_rst_rsp got %h want 0", {rsp_valid, req_ready, rsp_id, rsp_out1, rsp_out2, rsp_out3}); end
    checks++; if ({dp_in1, dp_in2, dp_in3, hist_count} !== 17'h0) begin errors++; $display("FAIL mid_rst_dp got %h want 0", {dp_in1, dp_in2, dp_in3, hist_count}); end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b0;
    m_last = 2;
    checks++; if (rsp_valid !== 1'b0 || hist_count !== 4'd0) begin errors++; $display("FAIL mid_after got vld=%b cnt=%0d want 0/0", rsp_valid, hist_count); end
    randomize_ops();
    drive_txn(3'b111, 0, ob);
    checks++; if (ob.grant !== 3'b001 || ob.id !== 2'd0) begin errors++; $display("FAIL mid_first_grant got %b id %0d want 001 id 0", ob.grant, ob.id); end
    m_last = 0;
  endtask

  task automatic test_history();
    txn_obs_t ob;
    logic [7:0] log_q [$];
    logic [7:0] exp_slot;
    int id, total, exp_cnt;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      randomize_ops();
      id = n % 3;
      op1[id] = 4'(n + 1);
      drive_txn(3'(1 << id), n % 2, ob);
      checks++; if (ob.id !== 2'(id) || ob.o1 !== 4'(n + 1)) begin errors++; $display("FAIL hist_sched[%0d] got id %0d out1 %h want id %0d out1 %h", n, ob.id, ob.o1, id, 4'(n + 1)); end
      log_q.push_back({4'(id), 4'(n + 1)});
    end
    total = log_q.size();
    exp_cnt = (total > 8) ? 8 : total;
`ifndef MODULE1_SCHED_HIST_EN
    exp_cnt = 0;
`endif
    checks++; if (hist_count !== 4'(exp_cnt)) begin errors++; $display("FAIL hist_count got %0d want %0d", hist_count, exp_cnt); end
    for (int s = 0; s < 8; s++) begin
      exp_slot = 8'h00;
`ifdef MODULE1_SCHED_HIST_EN
      for (int k = 0; k < total; k++) if (k % 8 == s) exp_slot = log_q[k];
`endif
      hist_rd_idx = 3'(s);
      #1;
      checks++; if (hist_rd_data !== exp_slot) begin errors++; $display("FAIL hist_slot[%0d] got %h want %h", s, hist_rd_data, exp_slot); end
    end
    hist_rd_idx = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_history();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
